// File: rtl/command_frame_tx.sv
// Serial command-link frame transmitter: 16-bit command + N buffered 32-bit words, one byte per clock.
// Optional trailing checksum byte enabled by defining COMMAND_FRAME_CSUM_EN.
module command_frame_tx #(
  parameter real TCQ            = 0.1,
  parameter int  FIFO_DEPTH     = 16,
  parameter int  WORD_NUM_WIDTH = 5
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_i,
  input  logic                      tx_req_i,
  input  logic [15:0]               tx_cmd_i,
  input  logic [WORD_NUM_WIDTH-1:0] tx_word_num_i,
  output logic                      tx_busy_o,
  input  logic                      tx_data_vld_i,
  input  logic [31:0]               tx_data_i,
  output logic                      tx_data_rdy_o,
  input  logic                      slave_tx_rdy_i,
  output logic                      slave_tx_data_vld_o,
  output logic [7:0]                slave_tx_data_o,
  output logic                      tx_done_o,
  output logic                      tx_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reject configurations the pointer arithmetic and word-count field cannot represent.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("command_frame_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if ((1 << WORD_NUM_WIDTH) <= FIFO_DEPTH) begin : g_bad_num_width
    $error("command_frame_tx: 2**WORD_NUM_WIDTH must exceed FIFO_DEPTH");
  end
  if (TCQ < 0.0) begin : g_bad_tcq
    $error("command_frame_tx: TCQ must be non-negative");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CMD_H,
    CMD_L,
    DATA,
`ifdef COMMAND_FRAME_CSUM_EN
    CSUM,
`endif
    GAP
  } state_t;

`ifdef COMMAND_FRAME_CSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = GAP;
`endif

  state_t state, state_nxt;

  logic [31:0]               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_count;
  logic                      push, pop;
  logic [31:0]               fifo_head;

  logic [15:0]               cmd_q;
  logic [WORD_NUM_WIDTH-1:0] num_q;
  logic [WORD_NUM_WIDTH-1:0] word_cnt;
  logic [1:0]                byte_idx;
  logic                      err_q;
  logic                      num_too_big;
  logic                      count_ok;
  logic                      last_word;
  logic                      vld;
  logic [7:0]                byte_out;
  logic                      done;
`ifdef COMMAND_FRAME_CSUM_EN
  logic [7:0]                csum_q;
`endif

  // ---------------------------------------------------------------- payload FIFO
  assign tx_data_rdy_o = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push          = tx_data_vld_i & tx_data_rdy_o;
  assign fifo_head     = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count define what is valid, and
  // leaving the array unreset lets it map onto RAM primitives.
  always_ff @(posedge clk_sys_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update from
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame FSM
  assign num_too_big = (int'(tx_word_num_i) > FIFO_DEPTH);
  assign count_ok    = (int'(fifo_count) >= int'(num_q));
  assign last_word   = (word_cnt == num_q - WORD_NUM_WIDTH'(1));

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path through the
  // case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    vld       = 1'b0;
    byte_out  = 8'h00;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_req_i && !num_too_big) state_nxt = WAIT;
      end
      WAIT: begin
        if (count_ok && slave_tx_rdy_i) state_nxt = CMD_H;
      end
      CMD_H: begin
        vld       = 1'b1;
        byte_out  = cmd_q[15:8];
        state_nxt = CMD_L;
      end
      CMD_L: begin
        vld       = 1'b1;
        byte_out  = cmd_q[7:0];
        state_nxt = (num_q != '0) ? DATA : TAIL;
      end
      DATA: begin
        vld = 1'b1;
        case (byte_idx)
          2'd0:    byte_out = fifo_head[31:24];
          2'd1:    byte_out = fifo_head[23:16];
          2'd2:    byte_out = fifo_head[15:8];
          default: byte_out = fifo_head[7:0];
        endcase
        if (byte_idx == 2'd3) begin
          pop = 1'b1;
          if (last_word) state_nxt = TAIL;
        end
      end
`ifdef COMMAND_FRAME_CSUM_EN
      CSUM: begin
        vld       = 1'b1;
        byte_out  = csum_q;
        state_nxt = GAP;
      end
`endif
      GAP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame context and byte/word position counters.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      cmd_q    <= '0;
      num_q    <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && tx_req_i && num_too_big;
      if ((state == IDLE) && tx_req_i) begin
        cmd_q <= tx_cmd_i;
        num_q <= tx_word_num_i;
      end
      if (state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word_cnt <= word_cnt + WORD_NUM_WIDTH'(1);
      end else begin
        byte_idx <= '0;
        word_cnt <= '0;
      end
    end
  end

`ifdef COMMAND_FRAME_CSUM_EN
  // Running byte sum restarted while waiting so it covers exactly the bytes of this frame.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i)              csum_q <= '0;
    else if (state == WAIT) csum_q <= '0;
    else if (vld)           csum_q <= csum_q + byte_out;
  end
`endif

  assign tx_busy_o           = (state != IDLE);
  assign slave_tx_data_vld_o = vld;
  assign slave_tx_data_o     = byte_out;
  assign tx_done_o           = done;
  assign tx_err_o            = err_q;

endmodule

// File: tb/tb_command_frame_tx.sv
// Self-checking bench for command_frame_tx: byte scoreboard fed at request time, checked on output.
module tb_command_frame_tx;

  localparam int DEPTH = 16;
`ifdef COMMAND_FRAME_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk_sys_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_req_i = 1'b0;
  logic [15:0] tx_cmd_i = '0;
  logic [4:0]  tx_word_num_i = '0;
  logic        tx_busy_o;
  logic        tx_data_vld_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic        tx_data_rdy_o;
  logic        slave_tx_rdy_i = 1'b0;
  logic        slave_tx_data_vld_o;
  logic [7:0]  slave_tx_data_o;
  logic        tx_done_o;
  logic        tx_err_o;

  command_frame_tx #(.TCQ(0.1), .FIFO_DEPTH(DEPTH), .WORD_NUM_WIDTH(5)) dut (
    .clk_sys_i           (clk_sys_i),
    .rst_i               (rst_i),
    .tx_req_i            (tx_req_i),
    .tx_cmd_i            (tx_cmd_i),
    .tx_word_num_i       (tx_word_num_i),
    .tx_busy_o           (tx_busy_o),
    .tx_data_vld_i       (tx_data_vld_i),
    .tx_data_i           (tx_data_i),
    .tx_data_rdy_o       (tx_data_rdy_o),
    .slave_tx_rdy_i      (slave_tx_rdy_i),
    .slave_tx_data_vld_o (slave_tx_data_vld_o),
    .slave_tx_data_o     (slave_tx_data_o),
    .tx_done_o           (tx_done_o),
    .tx_err_o            (tx_err_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_cyc = -1;
  int req_cyc = 0;
  bit prev_vld = 1'b0;
  logic [7:0]  exp_q [$];
  logic [31:0] mfifo [$];

  always @(posedge clk_sys_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid byte must be the next scoreboard entry; the window may not
  // close while expected bytes remain.
  always @(negedge clk_sys_i) begin
    logic [7:0] exp_b;
    if (slave_tx_data_vld_o === 1'b1) begin
      check("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("frame_byte", 32'(slave_tx_data_o), 32'(exp_b));
        if (!prev_vld) first_cyc = cyc;
      end
    end else begin
      check("idle_data_zero", 32'(slave_tx_data_o), 0);
      check("vld_contiguous", 32'(prev_vld && (exp_q.size() != 0)), 0);
    end
    prev_vld = slave_tx_data_vld_o;
  end

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_data_vld_i = 1'b1;
    tx_data_i     = w;
    if (mfifo.size() < DEPTH) mfifo.push_back(w);
    tick();
    tx_data_vld_i = 1'b0;
  endtask

  // Pulse a request; checks busy/err one cycle later (idle: accept or error, busy: ignored).
  task automatic drive_req(input logic [15:0] cmd, input int n, input bit idle);
    if (idle) check("busy_before_req", 32'(tx_busy_o), 0);
    tx_req_i      = 1'b1;
    tx_cmd_i      = cmd;
    tx_word_num_i = 5'(n);
    req_cyc       = cyc;
    tick();
    tx_req_i = 1'b0;
    if (idle) begin
      check("busy_after_req", 32'(tx_busy_o), 32'(n <= DEPTH));
      check("err_after_req", 32'(tx_err_o), 32'(n > DEPTH));
    end else begin
      check("busy_ignored_req", 32'(tx_busy_o), 1);
      check("err_ignored_req", 32'(tx_err_o), 0);
    end
  endtask

  task automatic expect_frame(input logic [15:0] cmd, input int n);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'h00;
    exp_q.push_back(cmd[15:8]); sum += cmd[15:8];
    exp_q.push_back(cmd[7:0]);  sum += cmd[7:0];
    for (int i = 0; i < n; i++) begin
      w = mfifo.pop_front();
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        sum += w[8*b +: 8];
      end
    end
`ifdef COMMAND_FRAME_CSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit got;
    got = 1'b0;
    dc  = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_sys_i);
      if (tx_done_o === 1'b1) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    check("done_seen", 32'(got), 1);
    if (got) begin
      check("queue_drained", 32'(exp_q.size()), 0);
      check("busy_in_gap", 32'(tx_busy_o), 1);
    end
    tick();
  endtask

  initial begin
    int dc, dc1, cond_cyc, r;

    // Reset state
    repeat (3) tick();
    check("rst_vld", 32'(slave_tx_data_vld_o), 0);
    check("rst_data", 32'(slave_tx_data_o), 0);
    check("rst_busy", 32'(tx_busy_o), 0);
    check("rst_done", 32'(tx_done_o), 0);
    check("rst_err", 32'(tx_err_o), 0);
    check("rst_rdy", 32'(tx_data_rdy_o), 1);
    rst_i = 1'b0;
    slave_tx_rdy_i = 1'b1;
    tick();

    // Single-word frame: 10 01 12 34 56 78 (+25 with checksum)
    push_word(32'h1234_5678);
    drive_req(16'h1001, 1, 1'b1);
    expect_frame(16'h1001, 1);
    r = req_cyc;
    wait_done(100, dc);
    check("single_first_cyc", first_cyc, r + 2);
    check("single_done_cyc", dc, r + 8 + CS);

    // Command-only frame
    drive_req(16'h2000, 0, 1'b1);
    expect_frame(16'h2000, 0);
    r = req_cyc;
    wait_done(100, dc);
    check("cmdonly_first_cyc", first_cyc, r + 2);
    check("cmdonly_done_cyc", dc, r + 4 + CS);

    // Late data with back-pressure: frame starts one cycle after words present and rdy high
    slave_tx_rdy_i = 1'b0;
    drive_req(16'hA5C3, 2, 1'b1);
    push_word(32'hDEAD_BEEF);
    tick();
    tick();
    push_word(32'h0BAD_F00D);
    tick();
    expect_frame(16'hA5C3, 2);
    slave_tx_rdy_i = 1'b1;
    cond_cyc = cyc;
    wait_done(100, dc);
    check("late_first_cyc", first_cyc, cond_cyc + 1);
    check("late_done_cyc", dc, cond_cyc + 1 + 2 + 8 + CS);

    // Back-to-back: leftover words carry into the next frame; the second request lands in the
    // IDLE cycle after GAP, so vld is low for GAP + IDLE + WAIT between the frames.
    push_word(32'h1111_2222);
    push_word(32'h3333_4444);
    push_word(32'h5555_6666);
    drive_req(16'h7007, 1, 1'b1);
    expect_frame(16'h7007, 1);
    wait_done(100, dc1);
    drive_req(16'h8008, 2, 1'b1);
    expect_frame(16'h8008, 2);
    r = req_cyc;
    wait_done(100, dc);
    check("b2b_req_cyc", r, dc1 + 1);
    check("b2b_first_cyc", first_cyc, r + 2);
    check("b2b_low_cycles", first_cyc - dc1, 3);

    // Oversized request: error pulse, never busy, no bytes
    drive_req(16'h4004, 17, 1'b1);
    tick();
    check("err_one_cycle", 32'(tx_err_o), 0);
    check("err_not_busy", 32'(tx_busy_o), 0);

    // Fill past depth: 17th push dropped while rdy=0
    for (int i = 0; i < 17; i++) begin
      check("rdy_before_push", 32'(tx_data_rdy_o), 32'(i < DEPTH));
      push_word(32'hC000_0000 + 32'(i));
    end
    check("rdy_full", 32'(tx_data_rdy_o), 0);
    drive_req(16'h5005, 16, 1'b1);
    expect_frame(16'h5005, 16);
    r = req_cyc;
    repeat (5) tick();
    drive_req(16'h6006, 17, 1'b0);
    wait_done(200, dc);
    check("full_done_cyc", dc, r + 4 + 64 + CS);

    // Reset during byte 4 of an N=3 frame
    push_word(32'hAAAA_0001);
    push_word(32'hAAAA_0002);
    push_word(32'hAAAA_0003);
    drive_req(16'h3003, 3, 1'b1);
    expect_frame(16'h3003, 3);
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    exp_q.delete();
    mfifo.delete();
    check("midrst_vld", 32'(slave_tx_data_vld_o), 0);
    check("midrst_busy", 32'(tx_busy_o), 0);
    check("midrst_done", 32'(tx_done_o), 0);
    check("midrst_rdy", 32'(tx_data_rdy_o), 1);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_done", 32'(tx_done_o), 0);
    end

    // FIFO was flushed: the next N=1 frame must carry only the freshly pushed word
    push_word(32'hCAFE_F00D);
    drive_req(16'h9009, 1, 1'b1);
    expect_frame(16'h9009, 1);
    r = req_cyc;
    wait_done(100, dc);
    check("post_rst_done_cyc", dc, r + 8 + CS);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
